booth_acc: RTL and testbench
============================

BOOTH_ACC -- requirements
Module: booth_acc

Interface
REQ-001 Parameter ACC_W, default 13: accumulator width; SHALL satisfy ACC_W >= 9 + CNT_W.
REQ-002 Parameter CNT_W, default 4: product-count width; maximum run length is 2^CNT_W-1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  begin a run; sampled only in IDLE.
REQ-006 len  input  CNT_W  number of products in the run; sampled with start.
REQ-007 abort  input  1  synchronous cancel of a run in ACCUM.
REQ-008 prod_valid  input  1  upstream multiplier product is valid.
REQ-009 prod  input  9  unsigned product from the 4x4 Booth multiplier.
REQ-010 prod_ready  output  1  block accepts prod this cycle.
REQ-011 acc_valid  output  1  acc holds a finished run sum.
REQ-012 acc  output  ACC_W  unsigned accumulated sum.
REQ-013 out_ready  input  1  downstream accepts acc.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 The FSM SHALL have three states: IDLE, ACCUM and HOLD.
REQ-016 IDLE: prod_ready=0, acc_valid=0; on start with len!=0, acc<=0, cnt<=len, next ACCUM.
REQ-017 IDLE: on start with len==0, acc<=0, next HOLD; an empty run yields acc=0 with acc_valid.
REQ-018 ACCUM: prod_ready=1; on prod_valid&&prod_ready, acc<=acc+zero-extended prod and cnt<=cnt-1.
REQ-019 ACCUM: a handshake with cnt==1 SHALL move the FSM to HOLD in the same edge, so acc_valid rises the cycle after the last product.
REQ-020 ACCUM: prod_valid low SHALL stall; acc and cnt are held.
REQ-021 ACCUM: abort high SHALL return the FSM to IDLE, clear acc, and drop any concurrent product; abort takes priority over the handshake.
REQ-022 HOLD: acc_valid=1, prod_ready=0; acc SHALL be stable until the handshake.
REQ-023 HOLD: on out_ready, next IDLE; acc retains its value after leaving HOLD.
REQ-024 start SHALL be ignored outside IDLE; abort SHALL be ignored outside ACCUM.
REQ-025 Latency: len accepted products plus one cycle to acc_valid; back-to-back runs need one IDLE cycle between HOLD exit and the next start.
REQ-026 Addition SHALL be unsigned at ACC_W bits with no overflow possible under REQ-001; no saturation logic.
REQ-027 All outputs SHALL be registered or decoded only from state; there is no combinational path from prod_valid or out_ready to any output.

Reset
REQ-028 rst low SHALL asynchronously force IDLE with acc=0, cnt=0, prod_ready=0, acc_valid=0 and busy=0.
REQ-029 Reset mid-run SHALL discard the partial sum; no acc_valid pulse follows.
REQ-030 Release SHALL be synchronous to clk; the first start is honoured on the first edge after release.

Structure
REQ-031 A shared package booth_pkg SHALL hold the state enum (IDLE, ACCUM, HOLD) and the default ACC_W and CNT_W constants.
REQ-032 The FSM, counter and accumulator SHALL be implemented in the single module; no sub-module is instantiated.
REQ-033 The block sits directly downstream of booth; prod connects to booth's 9-bit result.

Verification
REQ-034 start, len=3; products 225, 100, 1, each one cycle -> acc_valid the next cycle, acc=326, busy=1 until out_ready.
REQ-035 start, len=0 -> HOLD next cycle, acc=0, acc_valid=1; out_ready -> IDLE.
REQ-036 len=15, prod=511 every cycle -> acc=7665, no wrap.
REQ-037 len=4; prod_valid toggled 1,0,0,1,1,0,1 -> exactly 4 products summed; stalls do not alter acc.
REQ-038 len=4, abort after 2 products together with prod_valid -> IDLE, acc=0, no acc_valid; start during HOLD is ignored.
REQ-039 rst asserted while in ACCUM with acc=50 -> immediate IDLE, acc=0, all outputs 0 with no clock edge required.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared definitions for the Booth product accumulator: state encoding and
// default widths used by booth_acc and anything that instantiates it.
package booth_pkg;

  // Width of one product from the 4x4 Booth multiplier.
  localparam int PROD_W    = 9;

  // Default accumulator and run-length counter widths.
  // ACC_W must be at least PROD_W + CNT_W so a full-length run of maximum
  // products can never wrap.
  localparam int ACC_W_DEF = 13;
  localparam int CNT_W_DEF = 4;

  // Run controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage : booth_pkg

// File: rtl/booth_acc.sv
// Booth product accumulator.
// Sums a run of 'len' unsigned 9-bit products arriving on a valid/ready
// stream, then presents the total on a valid/ready output until taken.
// Every output is either a register or a pure decode of the state register,
// so there is no combinational path from prod_valid or out_ready to outputs.
module booth_acc
  import booth_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,        // active-low, asynchronous assert
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic              abort,
  input  logic              prod_valid,
  input  logic [PROD_W-1:0] prod,
  output logic              prod_ready,
  output logic              acc_valid,
  output logic [ACC_W-1:0]  acc,
  input  logic              out_ready,
  output logic              busy
);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [ACC_W-1:0]   r_acc;

  logic               w_hs;
  logic [ACC_W-1:0]   w_prod_ext;
  logic               w_last;

  // A product is consumed only while accumulating; ready is a state decode.
  assign w_hs       = (r_state == ACCUM) && prod_valid;
  assign w_prod_ext = {{(ACC_W-PROD_W){1'b0}}, prod};
  assign w_last     = (r_cnt == {{(CNT_W-1){1'b0}}, 1'b1});

  // Run controller: state, remaining-product counter and running sum.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          // acc keeps the last finished sum until a new run begins.
          if (start) begin
            r_acc <= '0;
            r_cnt <= len;
            if (len == '0) begin
              r_state <= HOLD;   // empty run: report zero immediately
            end else begin
              r_state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          // abort wins over a concurrent product, which is dropped.
          if (abort) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
          end else if (w_hs) begin
            r_acc <= r_acc + w_prod_ext;
            r_cnt <= r_cnt - 1'b1;
            if (w_last) begin
              r_state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_acc   <= '0;
        end
      endcase
    end
  end

  assign prod_ready = (r_state == ACCUM);
  assign acc_valid  = (r_state == HOLD);
  assign busy       = (r_state != IDLE);
  assign acc        = r_acc;

endmodule : booth_acc

// File: tb/tb_booth_acc.sv
// Directed bench for booth_acc: hand-computed sums, stalls, abort,
// empty runs, the no-wrap boundary and asynchronous reset.
module tb_booth_acc;

  localparam int ACC_W = 13;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] len;
  logic             abort;
  logic             prod_valid;
  logic [8:0]       prod;
  logic             prod_ready;
  logic             acc_valid;
  logic [ACC_W-1:0] acc;
  logic             out_ready;
  logic             busy;

  int n_vec = 0;
  int n_err = 0;

  booth_acc #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .len        (len),
    .abort      (abort),
    .prod_valid (prod_valid),
    .prod       (prod),
    .prod_ready (prod_ready),
    .acc_valid  (acc_valid),
    .acc        (acc),
    .out_ready  (out_ready),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // Advance one clock; sample point is 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string tag, input logic r, input logic v,
                          input logic b, input logic [31:0] a);
    chk({tag, ".ready"}, {31'd0, prod_ready}, {31'd0, r});
    chk({tag, ".valid"}, {31'd0, acc_valid}, {31'd0, v});
    chk({tag, ".busy"},  {31'd0, busy},      {31'd0, b});
    chk({tag, ".acc"},   {19'd0, acc},       a);
  endtask

  int exp_sum;
  logic [8:0] pv [7];
  logic       vv [7];

  initial begin
    rst = 1'b0; start = 1'b0; len = '0; abort = 1'b0;
    prod_valid = 1'b0; prod = '0; out_ready = 1'b0;

    // Reset state
    #2;
    chk_outs("reset", 1'b0, 1'b0, 1'b0, 0);
    tick(); tick();
    rst = 1'b1;

    // Run of three products: 225 + 100 + 1 = 326
    start = 1'b1; len = 4'd3;
    tick();
    start = 1'b0;
    chk_outs("r3.start", 1'b1, 1'b0, 1'b1, 0);
    prod_valid = 1'b1; prod = 9'd225; tick();
    chk({"r3.p0"}, {19'd0, acc}, 225);
    prod = 9'd100; tick();
    chk({"r3.p1"}, {19'd0, acc}, 325);
    prod = 9'd1; tick();
    prod_valid = 1'b0;
    chk_outs("r3.done", 1'b0, 1'b1, 1'b1, 326);
    tick();
    chk_outs("r3.hold", 1'b0, 1'b1, 1'b1, 326);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk_outs("r3.exit", 1'b0, 1'b0, 1'b0, 326);

    // Empty run; start and abort while in HOLD are ignored
    start = 1'b1; len = 4'd0; tick(); start = 1'b0;
    chk_outs("r0.hold", 1'b0, 1'b1, 1'b1, 0);
    start = 1'b1; len = 4'd5; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    chk_outs("r0.ign", 1'b0, 1'b1, 1'b1, 0);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk_outs("r0.exit", 1'b0, 1'b0, 1'b0, 0);

    // Maximum run of maximum products: 15 * 511 = 7665, no wrap
    start = 1'b1; len = 4'd15; tick(); start = 1'b0;
    prod_valid = 1'b1; prod = 9'd511;
    for (int i = 0; i < 14; i++) tick();
    chk_outs("r15.p13", 1'b1, 1'b0, 1'b1, 14 * 511);
    tick();
    prod_valid = 1'b0;
    chk_outs("r15.done", 1'b0, 1'b1, 1'b1, 7665);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk({"r15.exit.busy"}, {31'd0, busy}, 0);

    // Stalled run: valid pattern 1,0,0,1,1,0,1 with junk on stall cycles
    vv[0] = 1'b1; pv[0] = 9'd10;
    vv[1] = 1'b0; pv[1] = 9'd200;
    vv[2] = 1'b0; pv[2] = 9'd300;
    vv[3] = 1'b1; pv[3] = 9'd20;
    vv[4] = 1'b1; pv[4] = 9'd30;
    vv[5] = 1'b0; pv[5] = 9'd400;
    vv[6] = 1'b1; pv[6] = 9'd40;
    start = 1'b1; len = 4'd4; tick(); start = 1'b0;
    exp_sum = 0;
    for (int i = 0; i < 7; i++) begin
      prod_valid = vv[i]; prod = pv[i];
      tick();
      if (vv[i]) exp_sum += int'(pv[i]);
      chk($sformatf("stall.c%0d.acc", i), {19'd0, acc}, exp_sum);
    end
    prod_valid = 1'b0;
    chk_outs("stall.done", 1'b0, 1'b1, 1'b1, 100);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // Abort after two products, concurrent product dropped
    start = 1'b1; len = 4'd4; tick(); start = 1'b0;
    prod_valid = 1'b1; prod = 9'd5; tick();
    prod = 9'd6; tick();
    chk({"abort.pre"}, {19'd0, acc}, 11);
    prod = 9'd7; abort = 1'b1; tick(); abort = 1'b0; prod_valid = 1'b0;
    chk_outs("abort.post", 1'b0, 1'b0, 1'b0, 0);
    tick();
    chk_outs("abort.after", 1'b0, 1'b0, 1'b0, 0);

    // Asynchronous reset mid-run with acc = 50
    start = 1'b1; len = 4'd5; tick(); start = 1'b0;
    prod_valid = 1'b1; prod = 9'd20; tick();
    prod = 9'd30; tick();
    prod_valid = 1'b0;
    chk({"arst.pre"}, {19'd0, acc}, 50);
    #3 rst = 1'b0;
    #1;
    chk_outs("arst.now", 1'b0, 1'b0, 1'b0, 0);
    tick(); tick();
    chk_outs("arst.held", 1'b0, 1'b0, 1'b0, 0);

    // First start after release is honoured on the first edge
    rst = 1'b1; start = 1'b1; len = 4'd1; tick(); start = 1'b0;
    chk_outs("rel.start", 1'b1, 1'b0, 1'b1, 0);
    prod_valid = 1'b1; prod = 9'd9; tick(); prod_valid = 1'b0;
    chk_outs("rel.done", 1'b0, 1'b1, 1'b1, 9);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_booth_acc
